// File: rtl/sam_rv32i_pipe.sv
// sam_rv32i_pipe: 5-stage RV32I subset core with forwarding, load-use stall and branch flush.
// Writeback appears 5 edges after fetch; run=0 freezes every stage (no valid/ready backpressure).
module sam_rv32i_pipe #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          RN,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   NPC,
  output logic [31:0]                   WB_OUT,
  output logic                          wb_valid,
  output logic                          stall,
  output logic [CNT_W-1:0]              retired
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ins;
  } ifid_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_t     op;
    logic        use_imm;
    logic        we;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        br_ne;
  } idex_t;

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic        we;
    logic        is_load;
    logic        is_store;
    logic [31:0] alu;
    logic [31:0] sdat;
  } exmem_t;

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] res;
  } memwb_t;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] regs [32];

  ifid_t  ifid;
  idex_t  idex;
  exmem_t exmem;
  memwb_t memwb;

  logic [IAW-1:0] fidx;
  logic [DAW-1:0] didx;
  assign fidx = NPC[IAW+1:2];
  assign didx = exmem.alu[DAW+1:2];

  // ---------------- ID ----------------
  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] rd1, rd2;
  logic        use_rs1, use_rs2;
  logic        wb_fire;
  logic        load_use;
  idex_t       dec;

  assign ins   = ifid.ins;
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};

  assign wb_fire = memwb.vld && memwb.we;

  // Register file is written at the WB edge, so an ID read in that cycle bypasses it.
  always_comb begin
    rd1 = regs[ins[19:15]];
    rd2 = regs[ins[24:20]];
    if (wb_fire && memwb.rd == ins[19:15]) rd1 = memwb.res;
    if (wb_fire && memwb.rd == ins[24:20]) rd2 = memwb.res;
  end

  always_comb begin
    dec         = '0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    dec.vld     = ifid.vld;
    dec.pc      = ifid.pc;
    dec.rs1     = ins[19:15];
    dec.rs2     = ins[24:20];
    dec.rd      = ins[11:7];
    dec.rs1_val = rd1;
    dec.rs2_val = rd2;
    dec.op      = ALU_ADD;
    case (opc)
      OPC_R, OPC_I: begin
        use_rs1     = 1'b1;
        use_rs2     = (opc == OPC_R);
        dec.use_imm = (opc == OPC_I);
        dec.imm     = imm_i;
        dec.we      = 1'b1;
        case (f3)
          3'b000:  dec.op = (opc == OPC_R && ins[30]) ? ALU_SUB : ALU_ADD;
          3'b111:  dec.op = ALU_AND;
          3'b110:  dec.op = ALU_OR;
          3'b100:  dec.op = ALU_XOR;
          3'b010:  dec.op = ALU_SLT;
          3'b001:  dec.op = ALU_SLL;
          3'b101:  dec.op = ALU_SRL;
          default: dec.we = 1'b0;
        endcase
      end
      OPC_LW: begin
        if (f3 == 3'b010) begin
          use_rs1     = 1'b1;
          dec.use_imm = 1'b1;
          dec.imm     = imm_i;
          dec.we      = 1'b1;
          dec.is_load = 1'b1;
        end
      end
      OPC_SW: begin
        if (f3 == 3'b010) begin
          use_rs1      = 1'b1;
          use_rs2      = 1'b1;
          dec.use_imm  = 1'b1;
          dec.imm      = imm_s;
          dec.is_store = 1'b1;
        end
      end
      OPC_BR: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          use_rs1       = 1'b1;
          use_rs2       = 1'b1;
          dec.imm       = imm_b;
          dec.is_branch = 1'b1;
          dec.br_ne     = f3[0];
        end
      end
      default: ;
    endcase
    if (dec.rd == 5'd0) dec.we = 1'b0;
  end

  // we already excludes rd=0, so an LW to x0 never stalls.
  assign load_use = idex.vld && idex.is_load && idex.we && ifid.vld &&
                    ((use_rs1 && dec.rs1 == idex.rd) || (use_rs2 && dec.rs2 == idex.rd));
  assign stall = load_use;

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y, br_target;
  logic        br_taken;
  exmem_t      ex_nxt;

  // Loads in EX/MEM have no data yet, so they are only forwarded once in MEM/WB.
  always_comb begin
    fwd_a = idex.rs1_val;
    if (exmem.vld && exmem.we && !exmem.is_load && exmem.rd == idex.rs1) fwd_a = exmem.alu;
    else if (memwb.vld && memwb.we && memwb.rd == idex.rs1)              fwd_a = memwb.res;
    fwd_b = idex.rs2_val;
    if (exmem.vld && exmem.we && !exmem.is_load && exmem.rd == idex.rs2) fwd_b = exmem.alu;
    else if (memwb.vld && memwb.we && memwb.rd == idex.rs2)              fwd_b = memwb.res;
  end

  assign alu_b = idex.use_imm ? idex.imm : fwd_b;

  always_comb begin
    case (idex.op)
      ALU_ADD: alu_y = fwd_a + alu_b;
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_OR:  alu_y = fwd_a | alu_b;
      ALU_XOR: alu_y = fwd_a ^ alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      ALU_SLL: alu_y = fwd_a << alu_b[4:0];
      ALU_SRL: alu_y = fwd_a >> alu_b[4:0];
      default: alu_y = '0;
    endcase
  end

  assign br_taken  = idex.vld && idex.is_branch && ((fwd_a == fwd_b) ^ idex.br_ne);
  assign br_target = idex.pc + idex.imm;

  always_comb begin
    ex_nxt          = '0;
    ex_nxt.vld      = idex.vld;
    ex_nxt.rd       = idex.rd;
    ex_nxt.we       = idex.we;
    ex_nxt.is_load  = idex.is_load;
    ex_nxt.is_store = idex.is_store;
    ex_nxt.alu      = alu_y;
    ex_nxt.sdat     = fwd_b;
  end

  // ---------------- MEM ----------------
  memwb_t mem_nxt;

  always_comb begin
    mem_nxt     = '0;
    mem_nxt.vld = exmem.vld;
    mem_nxt.rd  = exmem.rd;
    mem_nxt.we  = exmem.we;
    mem_nxt.res = exmem.is_load ? dmem[didx] : exmem.alu;
  end

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (RN) begin
      NPC      <= '0;
      ifid     <= '0;
      idex     <= '0;
      exmem    <= '0;
      memwb    <= '0;
      WB_OUT   <= '0;
      wb_valid <= 1'b0;
      retired  <= '0;
    end else if (run) begin
      if (br_taken) begin
        NPC  <= br_target;
        ifid <= '0;
        idex <= '0;
      end else if (load_use) begin
        idex <= '0;
      end else begin
        NPC  <= NPC + 32'd4;
        ifid <= '{vld: 1'b1, pc: NPC, ins: imem[fidx]};
        idex <= dec;
      end
      exmem    <= ex_nxt;
      memwb    <= mem_nxt;
      wb_valid <= wb_fire;
      if (wb_fire)   WB_OUT  <= memwb.res;
      if (memwb.vld) retired <= retired + CNT_W'(1);
    end else begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (RN) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (run && wb_fire) begin
      regs[memwb.rd] <= memwb.res;
    end
  end

  always_ff @(posedge clk) begin
    if (!RN && run && exmem.vld && exmem.is_store) dmem[didx] <= exmem.sdat;
  end

  always_ff @(posedge clk) begin
    if (!RN && !run && imem_we) imem[imem_addr] <= imem_wdata;
  end

endmodule

// File: tb/tb_sam_rv32i_pipe.sv
// Directed-program bench for sam_rv32i_pipe; every WB_OUT/NPC/stall value is hand-derived.
module tb_sam_rv32i_pipe;
  localparam int OP_R = 'h33;
  localparam int OP_I = 'h13;
  localparam int OP_L = 'h03;

  logic        clk;
  logic        RN;
  logic        run;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] NPC;
  logic [31:0] WB_OUT;
  logic        wb_valid;
  logic        stall;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;
  logic [31:0] prog [64];
  logic [31:0] exp7 [17];

  sam_rv32i_pipe #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .CNT_W(16)) dut (
    .clk(clk), .RN(RN), .run(run), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .NPC(NPC), .WB_OUT(WB_OUT), .wb_valid(wb_valid),
    .stall(stall), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int opc);
    logic [31:0] v, a, f, d, o;
    v = imm; a = rs1; f = f3; d = rd; o = opc;
    return {v[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] s7, b, a, f, d;
    s7 = f7; b = rs2; a = rs1; f = f3; d = rd;
    return {s7[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v, b, a;
    v = imm; b = rs2; a = rs1;
    return {v[11:5], b[4:0], a[4:0], 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v, b, a, f;
    v = imm; b = rs2; a = rs1; f = f3;
    return {v[12], v[10:5], b[4:0], a[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, OP_I);
  endfunction

  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return enc_r(0, rs2, rs1, 0, rd);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  task automatic do_reset();
    RN  = 1'b1;
    run = 1'b0;
    tick();
    RN  = 1'b0;
  endtask

  task automatic load_prog();
    run = 1'b0;
    for (int i = 0; i < 64; i++) begin
      imem_we    = 1'b1;
      imem_addr  = 6'(i);
      imem_wdata = prog[i];
      tick();
    end
    imem_we = 1'b0;
  endtask

  initial begin
    int k;
    RN = 1'b1; run = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
    tick();
    check("rst_npc", NPC, 32'd0);
    check("rst_wb_out", WB_OUT, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    RN = 1'b0;

    // Dependent ALU chain through EX/MEM and MEM/WB forwarding.
    clear_prog();
    prog[0] = addi(1, 0, 5);
    prog[1] = addi(2, 1, 3);
    prog[2] = add(3, 1, 2);
    do_reset(); load_prog();
    run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("t1_stall", 32'(stall), 32'd0);
      case (c)
        5: begin check("t1_wb5", WB_OUT, 32'd5); check("t1_v5", 32'(wb_valid), 32'd1); end
        6: check("t1_wb8", WB_OUT, 32'd8);
        7: begin check("t1_wb13", WB_OUT, 32'd13); check("t1_ret3", 32'(retired), 32'd3); end
        8: begin check("t1_nop_v", 32'(wb_valid), 32'd0); check("t1_hold", WB_OUT, 32'd13); end
        default: ;
      endcase
    end

    // Seed DMEM[0]=7; reset keeps DMEM contents.
    clear_prog();
    prog[0] = addi(1, 0, 7);
    prog[1] = enc_s(0, 1, 0);
    do_reset(); load_prog();
    run = 1'b1;
    repeat (8) tick();

    // Load-use: one stall cycle, then forward from MEM/WB.
    clear_prog();
    prog[0] = enc_i(0, 0, 2, 4, OP_L);
    prog[1] = add(5, 4, 4);
    do_reset(); load_prog();
    run = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check("t2_stall", 32'(stall), (c == 2) ? 32'd1 : 32'd0);
      case (c)
        5: check("t2_lw", WB_OUT, 32'd7);
        6: check("t2_bubble_v", 32'(wb_valid), 32'd0);
        7: begin check("t2_add", WB_OUT, 32'd14); check("t2_ret2", 32'(retired), 32'd2); end
        default: ;
      endcase
    end

    // Taken branch squashes the next instruction; add x8 proves x6 stayed 0.
    clear_prog();
    prog[0] = enc_b(8, 0, 0, 0);
    prog[1] = addi(6, 0, 1);
    prog[2] = addi(7, 0, 2);
    prog[3] = add(8, 6, 7);
    do_reset(); load_prog();
    run = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      case (c)
        1: check("t3_npc1", NPC, 32'd4);
        2: check("t3_npc2", NPC, 32'd8);
        3: check("t3_npc_br", NPC, 32'd8);
        4: check("t3_npc4", NPC, 32'd12);
        5, 6, 7: begin check("t3_nowb", 32'(wb_valid), 32'd0); check("t3_ret1", 32'(retired), 32'd1); end
        8: begin check("t3_x7", WB_OUT, 32'd2); check("t3_ret2", 32'(retired), 32'd2); end
        9: begin check("t3_x8", WB_OUT, 32'd2); check("t3_ret3", 32'(retired), 32'd3); end
        default: ;
      endcase
    end

    // Store then load, and a write to x0.
    clear_prog();
    prog[0] = addi(1, 0, 9);
    prog[1] = enc_s(4, 1, 0);
    prog[2] = enc_i(4, 0, 2, 2, OP_L);
    prog[3] = addi(0, 0, 5);
    prog[4] = add(3, 2, 0);
    do_reset(); load_prog();
    run = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("t4_stall", 32'(stall), 32'd0);
      case (c)
        5: check("t4_addi", WB_OUT, 32'd9);
        6: check("t4_sw_v", 32'(wb_valid), 32'd0);
        7: begin check("t4_lw", WB_OUT, 32'd9); check("t4_lw_v", 32'(wb_valid), 32'd1); end
        8: begin check("t4_x0_v", 32'(wb_valid), 32'd0); check("t4_x0_hold", WB_OUT, 32'd9); end
        9: begin check("t4_add", WB_OUT, 32'd9); check("t4_ret", 32'(retired), 32'd5); end
        default: ;
      endcase
    end

    // Reset mid-stream, then confirm registers were cleared and run=1 IMEM writes are ignored.
    clear_prog();
    prog[0] = addi(1, 0, 1);
    prog[1] = addi(2, 0, 2);
    prog[2] = addi(3, 0, 3);
    prog[3] = addi(4, 0, 4);
    do_reset(); load_prog();
    run = 1'b1;
    repeat (6) tick();
    check("t5_pre_ret", 32'(retired), 32'd2);
    RN = 1'b1;
    tick();
    RN = 1'b0; run = 1'b0;
    check("t5_npc", NPC, 32'd0);
    check("t5_ret", 32'(retired), 32'd0);
    check("t5_wb_out", WB_OUT, 32'd0);
    check("t5_wb_v", 32'(wb_valid), 32'd0);
    clear_prog();
    prog[0] = add(10, 1, 2);
    prog[1] = add(11, 3, 0);
    load_prog();
    check("t5_frozen_v", 32'(wb_valid), 32'd0);
    check("t5_frozen_ret", 32'(retired), 32'd0);
    imem_we = 1'b1; imem_addr = 6'd1; imem_wdata = addi(11, 0, 99);
    run = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      imem_we = 1'b0;
      if (c <= 4) check("t5_no_stale", 32'(wb_valid), 32'd0);
      if (c >= 5) begin
        check("t5_zero_v", 32'(wb_valid), 32'd1);
        check("t5_zero", WB_OUT, 32'd0);
      end
    end
    check("t5_ret2", 32'(retired), 32'd2);

    // Signed SLT and fetch wrap at IMEM_DEPTH*4.
    clear_prog();
    prog[0] = addi(9, 9, 1);
    prog[1] = addi(1, 0, -1);
    prog[2] = addi(2, 0, 1);
    prog[3] = enc_r(0, 2, 1, 2, 3);
    prog[4] = enc_r(0, 1, 2, 2, 4);
    do_reset(); load_prog();
    run = 1'b1;
    for (int c = 1; c <= 69; c++) begin
      tick();
      case (c)
        5:  check("t6_inc1", WB_OUT, 32'd1);
        6:  check("t6_m1", WB_OUT, 32'hFFFF_FFFF);
        8:  check("t6_slt_m1_1", WB_OUT, 32'd1);
        9:  begin check("t6_slt_1_m1", WB_OUT, 32'd0); check("t6_slt_v", 32'(wb_valid), 32'd1); end
        64: check("t6_npc_end", NPC, 32'd256);
        65: check("t6_npc_wrap", NPC, 32'd260);
        69: check("t6_inc2", WB_OUT, 32'd2);
        default: ;
      endcase
    end

    // ALU/immediate mix with a taken BNE and a not-taken BEQ, checked in writeback order.
    clear_prog();
    prog[0]  = addi(1, 0, 12);
    prog[1]  = addi(2, 0, 10);
    prog[2]  = enc_r(32, 2, 1, 0, 3);
    prog[3]  = enc_r(0, 2, 1, 7, 4);
    prog[4]  = enc_r(0, 2, 1, 6, 5);
    prog[5]  = enc_r(0, 2, 1, 4, 6);
    prog[6]  = enc_r(0, 2, 1, 1, 7);
    prog[7]  = enc_r(0, 2, 7, 5, 8);
    prog[8]  = enc_i(2, 1, 5, 9, OP_I);
    prog[9]  = enc_i(5, 1, 7, 10, OP_I);
    prog[10] = enc_i(3, 1, 6, 11, OP_I);
    prog[11] = enc_i(-1, 1, 4, 12, OP_I);
    prog[12] = enc_i(-5, 1, 2, 13, OP_I);
    prog[13] = enc_i(4, 2, 1, 14, OP_I);
    prog[14] = enc_b(8, 2, 1, 1);
    prog[15] = addi(15, 0, 77);
    prog[16] = addi(16, 0, 5);
    prog[17] = enc_b(8, 2, 1, 0);
    prog[18] = addi(17, 0, 6);
    prog[19] = add(18, 1, 1);
    exp7 = '{32'd12, 32'd10, 32'd2, 32'd8, 32'd14, 32'd6, 32'd12288, 32'd12, 32'd3,
             32'd4, 32'd15, 32'hFFFF_FFF3, 32'd0, 32'd160, 32'd5, 32'd6, 32'd24};
    do_reset(); load_prog();
    run = 1'b1;
    k = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (wb_valid) begin
        if (k < 17) check($sformatf("t7_wb%0d", k), WB_OUT, exp7[k]);
        k++;
      end
    end
    check("t7_count", 32'(k), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sam_rv32i_pipe.md
# sam_rv32i_pipe

Parametrised successor to the team's first 5-stage RV32I core (IF/ID/EX/MEM/WB) with configurable instruction and data memory depth. It uses real RV32I opcode encodings and adds full forwarding, load-use stall, branch flush, an instruction-memory load port and a retired-instruction counter. It is the CPU block at the top of the samsung-riscv task hierarchy; the testbench drives it directly.

## Interface
Parameters:
- IMEM_DEPTH, 64: instruction words; power of two, ≥4.
- DMEM_DEPTH, 64: data words; power of two, ≥4.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- RN  in  1  reset; synchronous, active-high.
- run  in  1  1 = pipeline advances; 0 = pipeline frozen, IMEM writable.
- imem_we  in  1  IMEM write strobe; honoured only when run=0.
- imem_addr  in  $clog2(IMEM_DEPTH)  IMEM word index.
- imem_wdata  in  32  instruction word.
- NPC  out  32  byte address of the instruction being fetched.
- WB_OUT  out  32  value written to the register file this cycle.
- wb_valid  out  1  1 when WB_OUT is a real write (rd≠0).
- stall  out  1  load-use stall active this cycle.
- retired  out  CNT_W  count of non-bubble instructions leaving WB.

## Operation
- Supported encodings: R-type 0110011 (ADD, SUB via funct7[5], AND, OR, XOR, SLT signed, SLL, SRL); I-type 0010011 (ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, with shamt from imm[4:0]); LW 0000011 (funct3=010); SW 0100011 (funct3=010); BEQ/BNE 1100011. Any other opcode is a NOP: no register write, no memory write, still counted as retired.
- Immediates follow the RV32I I/S/B formats, sign-extended; B-immediate bit 0 = 0.
- PC is a byte address. Fetch index = NPC[log2(IMEM_DEPTH)+1:2], wrapping modulo depth. Sequential NPC+4 wraps at 2^32.
- DMEM word index = effective address [log2(DMEM_DEPTH)+1:2], wrapping. Address bits [1:0] are ignored.
- Register file: 32×32. x0 reads 0 and ignores writes. Write-before-read: an ID read of the register WB writes in the same cycle returns the new value.
- Forwarding into EX operands, priority EX/MEM over MEM/WB. Never forward for rd=0 or from bubbles. A load result is forwarded only from MEM/WB.
- Load-use: if ID/EX holds an LW with rd≠0 and the ID instruction reads that rd as rs1 or rs2, then:
  - hold the PC and IF/ID for 1 cycle;
  - insert a bubble into ID/EX;
  - stall=1 for that cycle.
- Branch resolved in EX on forwarded operands. If taken: NPC ← branch PC + imm on the next edge, and IF/ID and ID/EX become bubbles (2-cycle penalty). A taken branch overrides a simultaneous load-use stall. Not-taken branches cost nothing.
- Bubble = valid bit 0 in a stage register; a bubble performs no writes.
- run=0: every pipeline register, NPC, register file, DMEM and the counter hold. IMEM writes occur. WB_OUT holds; wb_valid=0.
- run=1 with imem_we=1: the write is ignored.

## Timing
- RN=1 on an edge clears the following: NPC=0, all stage valid bits=0, all 32 registers=0, WB_OUT=0, wb_valid=0, stall=0, retired=0. IMEM and DMEM contents are kept.
- RN has priority over run. Reset mid-operation discards all in-flight instructions; there are no partial writes after that edge.
- First fetch occurs on the first edge with RN=0, run=1. That instruction's writeback is visible on WB_OUT 5 edges later.
- Throughput: 1 instruction/cycle, minus 1 cycle per load-use stall and 2 per taken branch.
- SW writes DMEM on the edge leaving MEM. An LW in the following instruction reads the new data.
- retired increments at the WB edge for each valid instruction and wraps at 2^CNT_W.
- Outputs are registered except stall (combinational from ID/EX and IF/ID).

## Test plan
- Load `addi x1,x0,5; addi x2,x1,3; add x3,x1,x2`, run → WB_OUT sequence 5, 8, 13 on consecutive cycles; no stall; retired=3.
- `lw x4,0(x0)` then `add x5,x4,x4`, with DMEM[0]=7 → stall=1 for exactly 1 cycle; x5=14; retired=2 after 7 cycles.
- `beq x0,x0,+8` followed by `addi x6,x0,1` and `addi x7,x0,2` → x6 stays 0, x7=2; NPC jumps 0→(branch PC+8); 2 bubbles, not retired.
- `addi x1,x0,9; sw x1,4(x0); lw x2,4(x0)` → DMEM[1]=9, x2=9. Also write to x0 → WB_OUT unchanged, wb_valid=0, x0 reads 0.
- Assert RN mid-stream after 3 fetches → next cycle: NPC=0, retired=0, all registers 0, no later writeback from flushed instructions. Also: run=0 with imem_we pulses loads IMEM; imem_we during run=1 leaves IMEM unchanged.
- NPC reaches IMEM_DEPTH*4 → fetch wraps to word 0. A `slt` with −1 vs 1 → result 1 (signed).
